// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the memory arbiter and the single-port memory.
// Handshake: a requester drives req with we/addr/wdata/lock and holds them stable until it
// sees gnt in the same cycle; a granted read returns rvalid (with rdata) exactly one cycle later.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  lock0;
    logic                  lock1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  rvalid0;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] mem_out;

    // Arbiter side.
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, mem_out,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_we, mem_addr, mem_data
    );

    // Requesters plus memory side.
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, mem_out,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter for a single-port synchronous memory: round-robin on contention,
// optional locked bursts per port, registered read-valid one cycle after a read grant.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    mem_arbiter_if.slave     bus,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  last_q;
    logic                  last_d;
    logic                  gnt0;
    logic                  gnt1;
    logic                  rv0_q;
    logic                  rv1_q;
    logic                  mem_we_c;
    logic [ADDR_WIDTH-1:0] mem_addr_c;
    logic [DATA_WIDTH-1:0] mem_data_c;

    // Grant and next-state decode; last_q names the port granted most recently.
    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        state_d = state_q;
        last_d  = last_q;
        if (!rst) begin
            unique case (state_q)
                ARB: begin
                    if (bus.req0 && bus.req1) begin
                        gnt0 = last_q;
                        gnt1 = !last_q;
                    end else begin
                        gnt0 = bus.req0;
                        gnt1 = bus.req1;
                    end
                    if (gnt0 && bus.lock0) begin
                        state_d = LOCK0;
                    end else if (gnt1 && bus.lock1) begin
                        state_d = LOCK1;
                    end
                end
                LOCK0: begin
                    gnt0 = bus.req0;
                    if (!bus.lock0) begin
                        state_d = ARB;
                    end
                end
                LOCK1: begin
                    gnt1 = bus.req1;
                    if (!bus.lock1) begin
                        state_d = ARB;
                    end
                end
                default: state_d = ARB;
            endcase
            if (gnt0) begin
                last_d = 1'b0;
            end else if (gnt1) begin
                last_d = 1'b1;
            end
        end
    end

    always_comb begin
        mem_we_c   = 1'b0;
        mem_addr_c = '0;
        mem_data_c = '0;
        if (gnt0) begin
            mem_we_c   = bus.we0;
            mem_addr_c = bus.addr0;
            mem_data_c = bus.wdata0;
        end else if (gnt1) begin
            mem_we_c   = bus.we1;
            mem_addr_c = bus.addr1;
            mem_data_c = bus.wdata1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            last_q  <= 1'b1;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            rv0_q   <= gnt0 & ~bus.we0;
            rv1_q   <= gnt1 & ~bus.we1;
        end
    end

    assign bus.gnt0     = gnt0;
    assign bus.gnt1     = gnt1;
    assign bus.mem_we   = mem_we_c;
    assign bus.mem_addr = mem_addr_c;
    assign bus.mem_data = mem_data_c;
    // A read granted just before rst rose must not surface while rst is high.
    assign bus.rvalid0  = rv0_q & ~rst;
    assign bus.rvalid1  = rv1_q & ~rst;
    assign bus.rdata0   = bus.mem_out;
    assign bus.rdata1   = bus.mem_out;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, checked every cycle
// against a transaction-level arbiter/memory model.
module tb_mem_arbiter;

  localparam int AW = 6;
  localparam int DW = 16;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          lock;
  } txn_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic [1:0] dbg_state;

  initial clk = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Memory: samples we/addr/data at the edge, read data valid the following cycle.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_data;
    bus.mem_out <= mem[bus.mem_addr];
  end

  // ---------------- model / scoreboard state ----------------
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_q[$];
  txn_t q0[$];
  txn_t q1[$];
  int   owner;   // -1 none, else port holding the lock
  int   last;    // port granted most recently
  logic exp_rv0, exp_rv1;
  logic have_edge;
  logic auto_gen;
  int   obs_g;
  logic obs_rv0, obs_rv1;
  logic [DW-1:0] obs_rdata0, obs_rdata1;
  int   n_tests, n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  function automatic txn_t idle_txn();
    txn_t t;
    t.we = 1'b0; t.addr = '0; t.data = '0; t.lock = 1'b0;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.we   = 1'($urandom_range(0, 1));
    t.addr = AW'($urandom_range(0, 15));
    t.data = DW'($urandom);
    t.lock = ($urandom_range(0, 3) == 0);
    return t;
  endfunction

  task automatic push(input int port, input logic we, input int addr, input int data, input logic lock);
    txn_t t;
    t.we = we; t.addr = AW'(addr); t.data = DW'(data); t.lock = lock;
    if (port == 0) q0.push_back(t); else q1.push_back(t);
  endtask

  task automatic drive();
    txn_t t0, t1;
    t0 = (q0.size() > 0) ? q0[0] : idle_txn();
    t1 = (q1.size() > 0) ? q1[0] : idle_txn();
    bus.req0 = (q0.size() > 0); bus.we0 = t0.we; bus.addr0 = t0.addr;
    bus.wdata0 = t0.data; bus.lock0 = t0.lock;
    bus.req1 = (q1.size() > 0); bus.we1 = t1.we; bus.addr1 = t1.addr;
    bus.wdata1 = t1.data; bus.lock1 = t1.lock;
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic cycle();
    int g;
    logic r0, r1;
    txn_t t0, t1, tg;
    logic [DW-1:0] d;
    drive();
    r0 = (q0.size() > 0);
    r1 = (q1.size() > 0);
    t0 = r0 ? q0[0] : idle_txn();
    t1 = r1 ? q1[0] : idle_txn();
    @(negedge clk);
    // Which port the rules accept this cycle.
    g = -1;
    if (!rst) begin
      if (owner == 0)      g = r0 ? 0 : -1;
      else if (owner == 1) g = r1 ? 1 : -1;
      else if (r0 && r1)   g = 1 - last;
      else if (r0)         g = 0;
      else if (r1)         g = 1;
    end
    tg = (g == 0) ? t0 : (g == 1) ? t1 : idle_txn();
    check("gnt0", 32'(bus.gnt0), 32'(g == 0));
    check("gnt1", 32'(bus.gnt1), 32'(g == 1));
    check("mem_we", 32'(bus.mem_we), 32'(tg.we));
    check("mem_addr", 32'(bus.mem_addr), 32'(tg.addr));
    check("mem_data", 32'(bus.mem_data), 32'(tg.data));
    check("rvalid0", 32'(bus.rvalid0), 32'(!rst && exp_rv0));
    check("rvalid1", 32'(bus.rvalid1), 32'(!rst && exp_rv1));
    if (!rst && (exp_rv0 || exp_rv1) && exp_q.size() > 0) begin
      d = exp_q.pop_front();
      if (exp_rv0) check("rdata0", 32'(bus.rdata0), 32'(d));
      else         check("rdata1", 32'(bus.rdata1), 32'(d));
    end
    if (have_edge)
      check("dbg_state", 32'(dbg_state), (owner < 0) ? 32'd0 : (owner == 0) ? 32'd1 : 32'd2);
    obs_g      = bus.gnt0 ? 0 : (bus.gnt1 ? 1 : -1);
    obs_rv0    = bus.rvalid0;
    obs_rv1    = bus.rvalid1;
    obs_rdata0 = bus.rdata0;
    obs_rdata1 = bus.rdata1;
    // Model advance at the rising edge.
    if (rst) begin
      owner = -1; last = 1; exp_rv0 = 1'b0; exp_rv1 = 1'b0;
      exp_q.delete();
    end else begin
      exp_rv0 = (g == 0) && !tg.we;
      exp_rv1 = (g == 1) && !tg.we;
      if (g >= 0) begin
        if (tg.we) ref_mem[tg.addr] = tg.data;
        else       exp_q.push_back(ref_mem[tg.addr]);
      end
      if (owner == 0 && !t0.lock)                owner = -1;
      else if (owner == 1 && !t1.lock)           owner = -1;
      else if (owner < 0 && g >= 0 && tg.lock)   owner = g;
      if (g >= 0) last = g;
      if (g == 0) void'(q0.pop_front());
      if (g == 1) void'(q1.pop_front());
    end
    @(posedge clk);
    #1;
    have_edge = 1'b1;
    if (auto_gen) begin
      if (q0.size() == 0 && $urandom_range(0, 9) < 6) q0.push_back(rand_txn());
      if (q1.size() == 0 && $urandom_range(0, 9) < 6) q1.push_back(rand_txn());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] old;
    n_tests = 0; n_fail = 0;
    owner = -1; last = 1; exp_rv0 = 1'b0; exp_rv1 = 1'b0;
    have_edge = 1'b0; auto_gen = 1'b0; obs_g = -1;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    do_reset();

    // Single read from port 0.
    push(0, 1'b0, 'h05, 0, 1'b0);
    cycle();
    check("r031_gnt", 32'(obs_g), 32'd0);
    cycle();
    check("r031_rvalid0", 32'(obs_rv0), 32'd1);
    check("r031_rvalid1", 32'(obs_rv1), 32'd0);

    // Write on port 0, read back on port 1.
    push(0, 1'b1, 'h0A, 'hBEEF, 1'b0);
    cycle();
    push(1, 1'b0, 'h0A, 0, 1'b0);
    cycle();
    check("r032_gnt1", 32'(obs_g), 32'd1);
    cycle();
    check("r032_rdata1", 32'(obs_rdata1), 32'hBEEF);

    // Continuous contention alternates 0,1,0,1...
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b0, i, 0, 1'b0);
      push(1, 1'b0, i + 8, 0, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("r033_alt", 32'(obs_g), 32'(i % 2));
    end
    check("r033_drained", 32'(q0.size() + q1.size()), 32'd0);

    // Port 1 locked burst of three reads stalls a waiting port 0.
    push(1, 1'b0, 'h11, 0, 1'b1);
    push(1, 1'b0, 'h12, 0, 1'b1);
    push(1, 1'b0, 'h13, 0, 1'b0);
    cycle();
    check("r034_g1a", 32'(obs_g), 32'd1);
    push(0, 1'b0, 'h20, 0, 1'b0);
    cycle();
    check("r034_g1b", 32'(obs_g), 32'd1);
    cycle();
    check("r034_g1c", 32'(obs_g), 32'd1);
    cycle();
    check("r034_g0", 32'(obs_g), 32'd0);
    cycle();

    // Reset right after a read grant swallows the rvalid.
    push(0, 1'b0, 'h07, 0, 1'b0);
    cycle();
    check("r035_gnt", 32'(obs_g), 32'd0);
    rst = 1'b1;
    cycle();
    check("r035_rvalid0", 32'(obs_rv0), 32'd0);
    check("r035_nognt", 32'(obs_g), -32'sd1);
    cycle();
    rst = 1'b0;
    push(0, 1'b0, 'h01, 0, 1'b0);
    push(1, 1'b0, 'h02, 0, 1'b0);
    cycle();
    check("r035_first", 32'(obs_g), 32'd0);
    check("r035_rv_after", 32'(obs_rv0), 32'd0);
    cycle();
    cycle();

    // Read then write to the same word, then re-read.
    old = ref_mem[3];
    push(0, 1'b0, 'h03, 0, 1'b0);
    push(0, 1'b1, 'h03, 'h1234, 1'b0);
    push(0, 1'b0, 'h03, 0, 1'b0);
    cycle();
    cycle();
    check("r036_old", 32'(obs_rdata0), 32'(old));
    cycle();
    cycle();
    check("r036_new", 32'(obs_rdata0), 32'h1234);

    // Random traffic with occasional reset pulses.
    auto_gen = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;
    auto_gen = 1'b0;
    for (int i = 0; i < 60 && (q0.size() + q1.size()) > 0; i++) cycle();
    check("drain", 32'(q0.size() + q1.size()), 32'd0);
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
